data_memory_ctrl: RTL and testbench

- Parametrised data memory for the pipeline MEM stage; successor to the plain 32-bit register-array memory.
- Adds byte/half/word stores with lane selection, sign/zero-extended loads, and write-first read-during-write.
- Adds misalignment detection and a self-clearing init state machine that zeroes the array after reset or on request.
- Byte-addressed; one word = 4 bytes; 1-cycle registered read latency.

---
 rtl/data_memory_ctrl_if.sv | 30 +++
 rtl/data_memory_ctrl.sv | 106 ++++++++++
 tb/tb_data_memory_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bundle between the MEM stage and the data memory.
interface data_memory_ctrl_if #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 8
);
    logic                  i_clear;
    logic                  i_r_en;
    logic [NB_ADDRESS-1:0] i_r_addr;
    logic [1:0]            i_r_size;
    logic                  i_r_unsigned;
    logic                  i_w_en;
    logic [NB_ADDRESS-1:0] i_w_addr;
    logic [NB_DATA-1:0]    i_w_data;
    logic [1:0]            i_w_size;
    logic [NB_DATA-1:0]    o_r_data;
    logic                  o_r_valid;
    logic                  o_misalign;
    logic                  o_busy;

    modport master (
        output i_clear, i_r_en, i_r_addr, i_r_size, i_r_unsigned,
        output i_w_en, i_w_addr, i_w_data, i_w_size,
        input  o_r_data, o_r_valid, o_misalign, o_busy
    );
    modport slave (
        input  i_clear, i_r_en, i_r_addr, i_r_size, i_r_unsigned,
        input  i_w_en, i_w_addr, i_w_data, i_w_size,
        output o_r_data, o_r_valid, o_misalign, o_busy
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed data memory with lane stores, extended loads and a zeroing FSM.
// Optional DATA_MEMORY_DEBUG_PORT_EN adds a registered word-index debug read port.
module data_memory_ctrl #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDRESS = 8,
    parameter int N_WORDS    = 64
) (
    input logic               i_clk,
    input logic               i_rst,
    data_memory_ctrl_if.slave bus
`ifdef DATA_MEMORY_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDRESS-3:0] i_dbg_addr,
    output logic [NB_DATA-1:0]    o_dbg_data
`endif
);
    localparam int NW = NB_ADDRESS - 2;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t             state_q, state_d;
    logic [NW-1:0]      cnt_q, cnt_d;
    logic [NB_DATA-1:0] r_data_q, r_data_d;
    logic               r_valid_q, r_valid_d;
    logic               misalign_q, misalign_d;
    logic               busy_q, busy_d;
    logic [NB_DATA-1:0] mem [N_WORDS];
    logic               idle, r_ok, w_ok, r_go, w_go;
    logic [3:0]         be;
    logic [NW-1:0]      w_idx, r_idx;
    logic [NB_DATA-1:0] w_lanes, w_word, rd_word, rd_sh;

    function automatic logic aligned(input logic [1:0] size, input logic [1:0] a);
        return size == 2'b00 || (size == 2'b01 && !a[0]) || (size == 2'b10 && a == 2'b00);
    endfunction

    always_comb begin
        idle    = state_q == IDLE;
        w_idx   = bus.i_w_addr[NB_ADDRESS-1:2];
        r_idx   = bus.i_r_addr[NB_ADDRESS-1:2];
        r_ok    = aligned(bus.i_r_size, bus.i_r_addr[1:0]);
        w_ok    = aligned(bus.i_w_size, bus.i_w_addr[1:0]);
        r_go    = idle && bus.i_r_en && r_ok;
        w_go    = idle && bus.i_w_en && w_ok;
        be      = bus.i_w_size == 2'b00 ? 4'b0001 << bus.i_w_addr[1:0] :
                  bus.i_w_size == 2'b01 ? (bus.i_w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        w_lanes = bus.i_w_size == 2'b00 ? {4{bus.i_w_data[7:0]}} :
                  bus.i_w_size == 2'b01 ? {2{bus.i_w_data[15:0]}} : bus.i_w_data;
        w_word  = mem[w_idx];
        for (int i = 0; i < 4; i++)
            if (be[i]) w_word[8*i +: 8] = w_lanes[8*i +: 8];
        // write-first: a same-word load sees the merged store result
        rd_word = (w_go && w_idx == r_idx) ? w_word : mem[r_idx];
        rd_sh   = rd_word >> {bus.i_r_addr[1:0], 3'b000};
        r_data_d = !r_go ? r_data_q :
                   bus.i_r_size == 2'b00 ? {{(NB_DATA-8){!bus.i_r_unsigned && rd_sh[7]}}, rd_sh[7:0]} :
                   bus.i_r_size == 2'b01 ? {{(NB_DATA-16){!bus.i_r_unsigned && rd_sh[15]}}, rd_sh[15:0]} :
                   rd_sh;
        r_valid_d  = r_go;
        misalign_d = idle && ((bus.i_r_en && !r_ok) || (bus.i_w_en && !w_ok));
        state_d    = idle ? (bus.i_clear ? CLEAR : IDLE) : (cnt_q == NW'(N_WORDS - 1) ? IDLE : CLEAR);
        cnt_d      = idle ? '0 : cnt_q + NW'(1);
        busy_d     = state_d == CLEAR;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            misalign_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_data_q   <= r_data_d;
            r_valid_q  <= r_valid_d;
            misalign_q <= misalign_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!idle) mem[cnt_q] <= '0;
        else if (w_go) mem[w_idx] <= w_word;
    end

    assign bus.o_r_data   = r_data_q;
    assign bus.o_r_valid  = r_valid_q;
    assign bus.o_misalign = misalign_q;
    assign bus.o_busy     = busy_q;

`ifdef DATA_MEMORY_DEBUG_PORT_EN
    logic [NB_DATA-1:0] dbg_q, dbg_d;

    always_comb dbg_d = mem[i_dbg_addr];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) dbg_q <= '0;
        else dbg_q <= dbg_d;
    end

    assign o_dbg_data = dbg_q;
`endif
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: scoreboard bench; expected load data is queued at issue and
// compared by a monitor whenever o_r_valid is seen.
module tb_data_memory_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e_mon;

    data_memory_ctrl_if #(.NB_DATA(32), .NB_ADDRESS(8)) bus ();

`ifdef DATA_MEMORY_DEBUG_PORT_EN
    logic [5:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    data_memory_ctrl #(.NB_DATA(32), .NB_ADDRESS(8), .N_WORDS(64)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave), .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data));
`else
    data_memory_ctrl #(.NB_DATA(32), .NB_ADDRESS(8), .N_WORDS(64)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.o_r_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: o_r_data=%h, required no valid load", bus.o_r_data);
            end else begin
                e_mon = exp_q.pop_front();
                if (bus.o_r_data !== e_mon) begin
                    fails++;
                    $display("FAIL load_data: got %h, required %h", bus.o_r_data, e_mon);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.i_clear = 0; bus.i_r_en = 0; bus.i_r_addr = 0; bus.i_r_size = 0; bus.i_r_unsigned = 0;
        bus.i_w_en = 0; bus.i_w_addr = 0; bus.i_w_data = 0; bus.i_w_size = 0;
    endtask

    // one request cycle; returns 2 time units after the capturing edge
    task automatic drive(input logic r_en, input logic [7:0] r_addr, input logic [1:0] r_size,
                         input logic uns, input logic w_en, input logic [7:0] w_addr,
                         input logic [31:0] w_data, input logic [1:0] w_size);
        bus.i_r_en = r_en; bus.i_r_addr = r_addr; bus.i_r_size = r_size; bus.i_r_unsigned = uns;
        bus.i_w_en = w_en; bus.i_w_addr = w_addr; bus.i_w_data = w_data; bus.i_w_size = w_size;
        @(posedge clk); #2;
        idle_inputs();
    endtask

    task automatic store(input logic [7:0] a, input logic [31:0] d, input logic [1:0] s);
        drive(0, 0, 0, 0, 1, a, d, s);
    endtask

    task automatic load(input logic [7:0] a, input logic [1:0] s, input logic uns, input logic [31:0] e);
        exp_q.push_back(e);
        drive(1, a, s, uns, 0, 0, 0, 0);
        tests++;
        if (bus.o_r_valid !== 1'b1) begin
            fails++;
            $display("FAIL load_valid @%h: got %b, required 1", a, bus.o_r_valid);
        end
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            idle_inputs();
            n++;
            if (!bus.o_busy) break;
        end
        tests++;
        if (n != 64) begin
            fails++;
            $display("FAIL %s: busy cycles %0d, required 64", name, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        #12;
        tests++;
        if (bus.o_busy !== 1 || bus.o_r_valid !== 0 || bus.o_misalign !== 0 || bus.o_r_data !== 0) begin
            fails++;
            $display("FAIL reset_state: busy=%b valid=%b mis=%b data=%h, required 1 0 0 0",
                     bus.o_busy, bus.o_r_valid, bus.o_misalign, bus.o_r_data);
        end
        @(posedge clk); #2;
        rst = 0;
        count_busy("init_busy");
        load(8'h00, 2'b10, 0, 32'h0);
        load(8'd68, 2'b10, 0, 32'h0);
        load(8'd252, 2'b10, 0, 32'h0);
    endtask

    task automatic test_ext_load();
        store(8'h10, 32'h80FF_1234, 2'b10);
        load(8'h13, 2'b00, 0, 32'hFFFF_FF80);
        load(8'h13, 2'b00, 1, 32'h0000_0080);
        load(8'h10, 2'b01, 0, 32'h0000_1234);
        load(8'h12, 2'b01, 0, 32'hFFFF_80FF);
        load(8'h12, 2'b01, 1, 32'h0000_80FF);
        load(8'h10, 2'b10, 0, 32'h80FF_1234);
    endtask

    task automatic test_lane_store();
        store(8'h10, 32'h0, 2'b10);
        store(8'h11, 32'h1234_56AB, 2'b00);
        load(8'h10, 2'b10, 0, 32'h0000_AB00);
        store(8'h16, 32'h9999_CAFE, 2'b01);
        load(8'h14, 2'b10, 0, 32'hCAFE_0000);
    endtask

    task automatic test_write_first();
        exp_q.push_back(32'hDEAD_BEEF);
        drive(1, 8'h20, 2'b10, 0, 1, 8'h20, 32'hDEAD_BEEF, 2'b10);
        exp_q.push_back(32'hDE11_BEEF);
        drive(1, 8'h20, 2'b10, 0, 1, 8'h22, 32'h0000_0011, 2'b00);
    endtask

    task automatic test_misalign();
        load(8'h20, 2'b10, 0, 32'hDE11_BEEF);
        drive(0, 0, 0, 0, 1, 8'h21, 32'hFFFF_FFFF, 2'b01);
        tests++;
        if (bus.o_misalign !== 1 || bus.o_r_valid !== 0) begin
            fails++;
            $display("FAIL mis_store: mis=%b valid=%b, required 1 0", bus.o_misalign, bus.o_r_valid);
        end
        @(posedge clk); #2;
        tests++;
        if (bus.o_misalign !== 0) begin
            fails++;
            $display("FAIL mis_pulse_width: mis=%b, required 0", bus.o_misalign);
        end
        drive(1, 8'h22, 2'b10, 0, 0, 0, 0, 0);
        tests++;
        if (bus.o_misalign !== 1 || bus.o_r_valid !== 0 || bus.o_r_data !== 32'hDE11_BEEF) begin
            fails++;
            $display("FAIL mis_load: mis=%b valid=%b data=%h, required 1 0 de11beef",
                     bus.o_misalign, bus.o_r_valid, bus.o_r_data);
        end
        drive(1, 8'h20, 2'b11, 0, 0, 0, 0, 0);
        tests++;
        if (bus.o_misalign !== 1 || bus.o_r_valid !== 0) begin
            fails++;
            $display("FAIL size11_load: mis=%b valid=%b, required 1 0", bus.o_misalign, bus.o_r_valid);
        end
        exp_q.push_back(32'hDE11_BEEF);
        drive(1, 8'h20, 2'b10, 0, 1, 8'h23, 32'h0, 2'b10);
        tests++;
        if (bus.o_misalign !== 1 || bus.o_r_valid !== 1) begin
            fails++;
            $display("FAIL mis_store_with_load: mis=%b valid=%b, required 1 1", bus.o_misalign, bus.o_r_valid);
        end
        load(8'h20, 2'b10, 0, 32'hDE11_BEEF);
    endtask

    task automatic test_clear_reset();
        store(8'h30, 32'h55AA_55AA, 2'b10);
        store(8'hFC, 32'h0BAD_F00D, 2'b10);
        load(8'h30, 2'b10, 0, 32'h55AA_55AA);
        bus.i_clear = 1;
        @(posedge clk); #2;
        idle_inputs();
        tests++;
        if (bus.o_busy !== 1) begin
            fails++;
            $display("FAIL clear_start: busy=%b, required 1", bus.o_busy);
        end
        repeat (10) @(posedge clk);
        #2 rst = 1;
        #1;
        tests++;
        if (bus.o_busy !== 1 || bus.o_r_valid !== 0) begin
            fails++;
            $display("FAIL reset_mid_clear: busy=%b valid=%b, required 1 0", bus.o_busy, bus.o_r_valid);
        end
        @(posedge clk); #2;
        rst = 0;
        bus.i_w_en = 1; bus.i_w_addr = 8'h30; bus.i_w_data = 32'h0000_0777; bus.i_w_size = 2'b10;
        bus.i_r_en = 1; bus.i_r_addr = 8'h30; bus.i_r_size = 2'b10;
        count_busy("reclear_busy");
        load(8'h30, 2'b10, 0, 32'h0);
        load(8'hFC, 2'b10, 0, 32'h0);
        load(8'h10, 2'b10, 0, 32'h0);
        load(8'h20, 2'b10, 0, 32'h0);
        load(8'h14, 2'b10, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_ext_load();
        test_lane_store();
        test_write_first();
        test_misalign();
        test_clear_reset();
        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_loads: %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
